// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP RISC front end: reset defaults, sequencer
// state encoding, next-PC select codes and the fetched-instruction payload.
package kgp_risc_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ST_W = 2;
    localparam int unsigned SEL_W = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INCR_DEFAULT = 4;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_REQ    = 2'd1;
    localparam logic [ST_W-1:0] ST_ISSUE  = 2'd2;
    localparam logic [ST_W-1:0] ST_HALTED = 2'd3;

    localparam logic [SEL_W-1:0] NPC_HOLD  = 2'd0;
    localparam logic [SEL_W-1:0] NPC_SEQ   = 2'd1;
    localparam logic [SEL_W-1:0] NPC_REDIR = 2'd2;
    localparam logic [SEL_W-1:0] NPC_PEND  = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/pc_seq_next.sv
// Next-PC mux: hold, sequential step, aligned redirect target, or pending target.
module pc_seq_next
    import kgp_risc_pkg::*;
#(
    parameter int unsigned PC_INCR = PC_INCR_DEFAULT
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic [XLEN-1:0]  pend_target,
    output logic [XLEN-1:0]  redirect_aligned_c,
    output logic [XLEN-1:0]  pc_nxt_c
);

    always_comb begin
        redirect_aligned_c = redirect_target & ~XLEN'(3);
        pc_nxt_c           = pc;
        case (sel)
            NPC_HOLD:  pc_nxt_c = pc;
            NPC_SEQ:   pc_nxt_c = pc + XLEN'(PC_INCR);
            NPC_REDIR: pc_nxt_c = redirect_aligned_c;
            NPC_PEND:  pc_nxt_c = pend_target;
            default:   pc_nxt_c = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: requests imem at PC, offers the word to decode,
// and follows redirects from execute (deferred while a fetch is outstanding).
module pc_sequencer
    import kgp_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_INCR  = PC_INCR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] issue_count
);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  redirect_aligned;
    logic             pend_v;
    logic [XLEN-1:0]  pend_target;
    logic [SEL_W-1:0] npc_sel;
    logic             capture;
    logic             count_inc;
    logic             pend_load;
    logic             pend_clr;
    logic             mis_set;
    fetch_pkt_t       pkt;

    pc_seq_next #(
        .PC_INCR (PC_INCR)
    ) u_next (
        .sel                (npc_sel),
        .pc                 (pc),
        .redirect_target    (redirect_target),
        .pend_target        (pend_target),
        .redirect_aligned_c (redirect_aligned),
        .pc_nxt_c           (pc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A fetch returning while a redirect is pending (or arriving) is dropped and refetched.
    always_comb begin
        state_nxt = state;
        npc_sel   = NPC_HOLD;
        capture   = 1'b0;
        count_inc = 1'b0;
        pend_load = 1'b0;
        pend_clr  = 1'b0;
        mis_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = halt ? ST_HALTED : ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        npc_sel  = NPC_REDIR;
                        pend_clr = 1'b1;
                        mis_set  = |redirect_target[1:0];
                    end else if (pend_v) begin
                        npc_sel  = NPC_PEND;
                        pend_clr = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
                end else if (redirect_valid) begin
                    pend_load = 1'b1;
                    mis_set   = |redirect_target[1:0];
                end
            end
            ST_ISSUE: begin
                if (redirect_valid) begin
                    npc_sel   = NPC_REDIR;
                    mis_set   = |redirect_target[1:0];
                    state_nxt = ST_REQ;
                end else if (instr_ready) begin
                    npc_sel   = NPC_SEQ;
                    count_inc = 1'b1;
                    state_nxt = halt ? ST_HALTED : ST_REQ;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            pend_v       <= 1'b0;
            pend_target  <= '0;
            pkt          <= '0;
            issue_count  <= '0;
            misalign_err <= 1'b0;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (pend_load) begin
                pend_v      <= 1'b1;
                pend_target <= redirect_aligned;
            end else if (pend_clr) begin
                pend_v <= 1'b0;
            end
            if (capture) begin
                pkt.word <= imem_rdata;
                pkt.pc   <= pc;
            end
            if (count_inc) begin
                issue_count <= issue_count + 32'd1;
            end
            if (mis_set) begin
                misalign_err <= 1'b1;
            end
            imem_req    <= (state_nxt == ST_REQ);
            instr_valid <= (state_nxt == ST_ISSUE);
            halted      <= (state_nxt == ST_HALTED);
        end
    end

    assign imem_addr = pc;
    assign instr     = pkt.word;
    assign instr_pc  = pkt.pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, checked
// every cycle against a transaction-rule reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int MD_IDLE  = 0;
    localparam int MD_FETCH = 1;
    localparam int MD_OFFER = 2;
    localparam int MD_STOP  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;
    logic        misalign_err;
    logic [31:0] issue_count;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_pend_v;
    logic [31:0] m_pend;
    logic [31:0] m_word;
    logic [31:0] m_wpc;
    logic [31:0] m_count;
    bit          m_mis;

    pc_sequencer #(
        .RESET_PC (RST_PC),
        .PC_INCR  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .issue_count     (issue_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = MD_IDLE;
        m_pc     = RST_PC;
        m_pend_v = 1'b0;
        m_pend   = 32'h0;
        m_word   = 32'h0;
        m_wpc    = 32'h0;
        m_count  = 32'h0;
        m_mis    = 1'b0;
    endtask

    // One clock of sequencer behaviour, stated as fetch/offer transaction rules.
    task automatic model_step(input bit rv, input logic [31:0] rt, input bit ack,
                              input logic [31:0] rd, input bit rdy, input bit hlt);
        logic [31:0] tgt;
        tgt = {rt[31:2], 2'b00};
        if (m_mode == MD_IDLE) begin
            m_mode = hlt ? MD_STOP : MD_FETCH;
        end else if (m_mode == MD_FETCH) begin
            if (rv && rt[1:0] != 2'b00) m_mis = 1'b1;
            if (ack && (rv || m_pend_v)) begin
                m_pc     = rv ? tgt : m_pend;
                m_pend_v = 1'b0;
            end else if (ack) begin
                m_word = rd;
                m_wpc  = m_pc;
                m_mode = MD_OFFER;
            end else if (rv) begin
                m_pend   = tgt;
                m_pend_v = 1'b1;
            end
        end else if (m_mode == MD_OFFER) begin
            if (rv) begin
                if (rt[1:0] != 2'b00) m_mis = 1'b1;
                m_pc   = tgt;
                m_mode = MD_FETCH;
            end else if (rdy) begin
                m_pc    = m_pc + 32'd4;
                m_count = m_count + 32'd1;
                m_mode  = hlt ? MD_STOP : MD_FETCH;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("imem_req",     32'(imem_req),     32'(m_mode == MD_FETCH));
        check_eq("imem_addr",    imem_addr,         m_pc);
        check_eq("instr_valid",  32'(instr_valid),  32'(m_mode == MD_OFFER));
        check_eq("instr",        instr,             m_word);
        check_eq("instr_pc",     instr_pc,          m_wpc);
        check_eq("halted",       32'(halted),       32'(m_mode == MD_STOP));
        check_eq("misalign_err", 32'(misalign_err), 32'(m_mis));
        check_eq("issue_count",  issue_count,       m_count);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit rv, input logic [31:0] rt, input bit ack,
                         input logic [31:0] rd, input bit rdy, input bit hlt);
        redirect_valid  = rv;
        redirect_target = rt;
        imem_ack        = ack;
        imem_rdata      = rd;
        instr_ready     = rdy;
        halt            = hlt;
        model_step(rv, rt, ack, rd, rdy, hlt);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_target = '0; imem_ack = 1'b0;
        imem_rdata = '0; instr_ready = 1'b0; halt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Straight-line fetch; redirect and ack in IDLE are ignored
        cycle(1'b1, 32'h0000_0300, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        check_eq("seq_addr0", imem_addr, 32'h0);
        check_eq("seq_req0", 32'(imem_req), 32'd1);
        cycle(1'b0, '0, 1'b1, 32'h1111_0000, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 32'h1111_0004, 1'b1, 1'b0);
        check_eq("seq_addr4", imem_addr, 32'h4);
        cycle(1'b0, '0, 1'b1, 32'h1111_0004, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 32'h1111_0008, 1'b1, 1'b0);
        check_eq("seq_addr8", imem_addr, 32'h8);
        cycle(1'b0, '0, 1'b1, 32'h1111_0008, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 32'h1111_000C, 1'b1, 1'b0);
        check_eq("seq_count3", issue_count, 32'd3);

        // Decode stall: offer held stable, no new request
        cycle(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b1, 32'h5555_5555, 1'b0, 1'b0);
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
            check_eq("stall_instr", instr, 32'hDEAD_BEEF);
            check_eq("stall_pc", instr_pc, 32'hC);
            check_eq("stall_noreq", 32'(imem_req), 32'd0);
        end

        // Redirect squashes the offered instruction
        cycle(1'b1, 32'h0000_0100, 1'b0, '0, 1'b1, 1'b0);
        check_eq("sq_count", issue_count, 32'd3);
        check_eq("sq_addr", imem_addr, 32'h100);
        check_eq("sq_valid", 32'(instr_valid), 32'd0);

        // Misaligned redirect deferred behind an unacked fetch at 0x40
        cycle(1'b0, '0, 1'b1, 32'hAAAA_0100, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0040, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0203, 1'b0, '0, 1'b0, 1'b0);
        check_eq("pend_addr_hold", imem_addr, 32'h40);
        check_eq("pend_mis", 32'(misalign_err), 32'd1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_eq("pend_addr_hold2", imem_addr, 32'h40);
        cycle(1'b0, '0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0);
        check_eq("pend_addr_new", imem_addr, 32'h200);
        check_eq("pend_dropped", 32'(instr_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 32'h600D_600D, 1'b0, 1'b0);
        check_eq("pend_ipc", instr_pc, 32'h200);
        check_eq("pend_instr", instr, 32'h600D_600D);

        // PC wraps from the top of the address space
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 32'h7777_7777, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check_eq("wrap_addr", imem_addr, 32'h0);

        // Halt waits for the offer, then absorbs redirects until reset
        cycle(1'b0, '0, 1'b1, 32'h4444_4444, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        check_eq("halt_wait", 32'(instr_valid), 32'd1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_noreq", 32'(imem_req), 32'd0);
        cycle(1'b1, 32'h0000_0500, 1'b1, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0601, 1'b0, '0, 1'b0, 1'b0);
        check_eq("halt_addr", imem_addr, 32'h4);
        check_eq("halt_count", issue_count, 32'd5);
        do_reset();
        check_eq("rst_addr", imem_addr, RST_PC);
        check_eq("rst_halted", 32'(halted), 32'd0);

        // Reset abandons an outstanding request
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0080, 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, '0, 1'b1, 32'h9999_9999, 1'b1, 1'b0);

        // Random traffic in several reset-separated episodes
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int n = 0; n < 400; n++) begin
                logic [31:0] rt;
                int unsigned kind;
                kind = $urandom_range(0, 3);
                if (kind == 0)      rt = $urandom;
                else if (kind == 1) rt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else                rt = $urandom & 32'h0000_0FFC;
                cycle($urandom_range(0, 9) == 0, rt, $urandom_range(0, 1) == 1,
                      $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
